// File: rtl/ram_loader.sv
// ram_loader: programming sequencer for the SAP-1 16x8 program RAM.
// Takes program bytes over a valid/ready handshake and writes them to
// addresses 0..LAST_ADDR. Each write gets one full cycle of address/data
// setup before the strobe and one full cycle of hold after it. A mod-256
// checksum of the written bytes is kept for the host to compare against.
module ram_loader #(
    parameter int LAST_ADDR = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       prog,
    output logic       write,
    output logic       ce,
    output logic [3:0] a,
    output logic [7:0] d,
    output logic       busy,
    output logic       done,
    output logic [7:0] sum
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [3:0] LAST = 4'(LAST_ADDR);

    state_t state;

    // Ready is decoded straight from the state so upstream sees it in the
    // same cycle the loader enters WAIT.
    assign in_ready = (state == WAIT);

    // The loader only ever writes the RAM, so its output driver stays off.
    assign ce = 1'b0;

    // Load sequencer: one pass of WAIT/SETUP/STROBE/HOLD per byte. Reset
    // clears prog and write asynchronously, so an aborted load never leaves
    // a strobe hanging on the RAM.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            prog  <= 1'b0;
            write <= 1'b0;
            a     <= 4'd0;
            d     <= 8'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT;
                        prog  <= 1'b1;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        a     <= 4'd0;
                        sum   <= 8'd0;
                    end
                end
                WAIT: begin
                    // No timeout: a stalled source simply parks the loader here.
                    if (in_valid) begin
                        d     <= in_data;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    write <= 1'b1;
                    state <= STROBE;
                end
                STROBE: begin
                    // The RAM captures d on this same edge; fold it into the sum.
                    write <= 1'b0;
                    sum   <= sum + d;
                    state <= HOLD;
                end
                HOLD: begin
                    // Address stops at the last location rather than wrapping.
                    if (a == LAST) begin
                        state <= IDLE;
                        prog  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        a     <= a + 4'd1;
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
